fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller that sequences the instruction memory. It owns the halfword-aligned fetch PC and the main/ISR ROM select, and classifies each fetched word as 16-bit compressed or 32-bit. It delivers one instruction per cycle to decode through a registered valid/ready stage. It also handles branch redirects, interrupt entry with return-PC save, and interrupt return.

## Interface
- ADDR_W, 12, fetch address width in bytes, matching the instruction memory address port
- ISR_BASE, 12'h000, first fetch address inside the ISR ROM
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- mem_addr  out  ADDR_W  byte address to instruction memory, always equal to pc, bit 0 always 0
- mem_sel_isr  out  1  ROM select to instruction memory (1 = ISR ROM), always equal to the in_isr state bit
- mem_inst  in  32  asynchronous read data for mem_addr, valid in the same cycle
- out_valid  out  1  output register holds an instruction
- out_ready  in  1  decode accepts the output register this cycle
- out_inst  out  32  instruction; upper 16 bits are don't-care when out_is_c=1
- out_pc  out  ADDR_W  byte address of out_inst
- out_is_c  out  1  out_inst is compressed (mem_inst[1:0] != 2'b11)
- out_isr  out  1  out_inst was fetched from the ISR ROM
- redirect_valid  in  1  branch/jump taken, flush and refetch
- redirect_addr  in  ADDR_W  redirect target; bit 0 ignored (forced 0)
- int_req  in  1  interrupt request, level, sampled every cycle
- iret  in  1  single-cycle pulse: return from ISR
- in_isr  out  1  controller is in ISR state

## Operation
- Two states: NORMAL (in_isr=0) and ISR (in_isr=1). Other registers: pc, epc, int_pending, and the output register.
- The output register is loaded when `load = !out_valid || out_ready`.
- int_pending is set on any cycle with int_req=1. It is cleared only when the interrupt is taken.
- Per-cycle priority, highest first:
  - **rst:** pc=0, epc=0, state=NORMAL, int_pending=0, out_valid=0, out_inst=0, out_pc=0, out_is_c=0, out_isr=0.
  - **redirect_valid:**
    - pc <= {redirect_addr[ADDR_W-1:1],1'b0}.
    - out_valid <= 0.
    - State is unchanged (redirect applies within the current ROM).
    - An iret in the same cycle is dropped.
  - **iret, state=ISR:**
    - pc <= epc, state <= NORMAL, out_valid <= 0.
    - A pending interrupt is not taken in this cycle.
  - **Interrupt take:** when state=NORMAL, int_pending=1, and load=1:
    - epc <= pc (the instruction not yet delivered).
    - pc <= ISR_BASE, state <= ISR, int_pending <= 0, out_valid <= 0.
  - **Sequential:** when load=1:
    - out_inst <= mem_inst, out_pc <= pc, out_isr <= in_isr, out_valid <= 1.
    - out_is_c <= (mem_inst[1:0] != 2'b11).
    - pc <= pc + (is_c ? 2 : 4).
  - **Otherwise (stall):** all registers hold.
- iret while in NORMAL is ignored.
- int_req while in ISR stays latched in int_pending (no nesting). It is taken at the first load after return.
- pc arithmetic is modulo 2^ADDR_W. 0xFFE+2 = 0x000 and 0xFFE+4 = 0x002. A 32-bit word at 0xFFE takes its upper half from halfword 0; the memory wraps.
- The ROM select changes in the same register update as pc, so mem_addr and mem_sel_isr always address the same ROM.

## Timing
- pc and in_isr are registered; mem_addr and mem_sel_isr are driven directly from them.
- Fetch-to-output latency is 1 cycle. Throughput is 1 instruction/cycle while out_ready=1.
- The output register is held stable while out_valid=1 and out_ready=0.
- Redirect, iret, and interrupt entry each cost exactly 1 bubble cycle (out_valid=0). The first target instruction appears with out_valid=1 on the following cycle.
- Reset: out_valid=0 in the cycle after rst is sampled. The first instruction, from pc=0 in the main ROM, is valid 1 cycle after rst deasserts.
- rst asserted mid-stall, mid-ISR, or with redirect_valid/iret/int_req simultaneously: reset values win, and int_pending is cleared.

## Test plan
- **Sequential fetch:**
  - Stimulus: after reset, main ROM holds 32-bit at 0x000, compressed at 0x004, 32-bit at 0x006; out_ready=1.
  - Required: out_pc = 0x000, 0x004, 0x006 on consecutive cycles, with out_is_c = 0, 1, 0.
- **Stall:**
  - Stimulus: out_ready=0 for 3 cycles with out_valid=1.
  - Required: out_inst/out_pc are unchanged, mem_addr is unchanged, and no instruction is skipped or duplicated after release.
- **Redirect:**
  - Stimulus: redirect_valid=1, redirect_addr=0x123, in the same cycle as iret=1 in ISR.
  - Required: one bubble, then out_pc=0x122, in_isr unchanged, iret ignored.
- **Interrupt round trip:**
  - Stimulus: int_req pulse with pc=0x040.
  - Required: epc=0x040, one bubble, out_pc=0x000 with out_isr=1, mem_sel_isr=1. Then iret gives one bubble, out_pc=0x040, out_isr=0.
- **Nested request and wrap:**
  - Stimulus: int_req during ISR. Separately, a 32-bit instruction at 0xFFE.
  - Required: the second interrupt is taken at the first load after iret. For the wrap case, out_inst = {halfword[0], halfword[0x7FF]} and next pc=0x002.
- **Reset mid-ISR:**
  - Stimulus: rst=1 while in ISR with int_pending=1.
  - Required: in_isr=0, out_valid=0, pc=0 next cycle, and no interrupt taken afterward without a new int_req.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the fetch PC and ROM select, classifies each
// fetched word as compressed or 32-bit, and feeds decode through a valid/ready register.
module fetch_sequencer #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] ISR_BASE = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_sel_isr,
    input  logic [31:0]       mem_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_is_c,
    output logic              out_isr,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              int_req,
    input  logic              iret,
    output logic              in_isr
);

    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_ISR    = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic              int_pending_q, int_pending_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_inst_q, out_inst_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic              out_is_c_q, out_is_c_d;
    logic              out_isr_q, out_isr_d;

    logic load;
    logic fetch_is_c;

    assign load       = !out_valid_q || out_ready;
    assign fetch_is_c = (mem_inst[1:0] != 2'b11);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        epc_d         = epc_q;
        int_pending_d = int_pending_q | int_req;
        out_valid_d   = out_valid_q;
        out_inst_d    = out_inst_q;
        out_pc_d      = out_pc_q;
        out_is_c_d    = out_is_c_q;
        out_isr_d     = out_isr_q;

        if (redirect_valid) begin
            // Redirect stays within the current ROM; a coincident iret is dropped.
            pc_d        = {redirect_addr[ADDR_W-1:1], 1'b0};
            out_valid_d = 1'b0;
        end else if (iret && state_q == ST_ISR) begin
            pc_d        = epc_q;
            state_d     = ST_NORMAL;
            out_valid_d = 1'b0;
        end else if (state_q == ST_NORMAL && int_pending_q && load) begin
            // The instruction at pc has not been delivered yet, so it is the return point.
            epc_d         = pc_q;
            pc_d          = ISR_BASE;
            state_d       = ST_ISR;
            int_pending_d = 1'b0;
            out_valid_d   = 1'b0;
        end else if (load) begin
            out_inst_d  = mem_inst;
            out_pc_d    = pc_q;
            out_isr_d   = state_q;
            out_is_c_d  = fetch_is_c;
            out_valid_d = 1'b1;
            pc_d        = pc_q + (fetch_is_c ? ADDR_W'(2) : ADDR_W'(4));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_NORMAL;
            pc_q          <= '0;
            epc_q         <= '0;
            int_pending_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_inst_q    <= '0;
            out_pc_q      <= '0;
            out_is_c_q    <= 1'b0;
            out_isr_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            epc_q         <= epc_d;
            int_pending_q <= int_pending_d;
            out_valid_q   <= out_valid_d;
            out_inst_q    <= out_inst_d;
            out_pc_q      <= out_pc_d;
            out_is_c_q    <= out_is_c_d;
            out_isr_q     <= out_isr_d;
        end
    end

    assign mem_addr    = pc_q;
    assign mem_sel_isr = state_q;
    assign in_isr      = state_q;
    assign out_valid   = out_valid_q;
    assign out_inst    = out_inst_q;
    assign out_pc      = out_pc_q;
    assign out_is_c    = out_is_c_q;
    assign out_isr     = out_isr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios plus randomized traffic,
// all checked against an architectural model of the fetch rules.
module tb_fetch_sequencer;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] mem_addr;
    logic          mem_sel_isr;
    logic [31:0]   mem_inst;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_inst;
    logic [AW-1:0] out_pc;
    logic          out_is_c;
    logic          out_isr;
    logic          redirect_valid;
    logic [AW-1:0] redirect_addr;
    logic          int_req;
    logic          iret;
    logic          in_isr;

    always #5 clk = ~clk;

    fetch_sequencer #(.ADDR_W(AW), .ISR_BASE(12'h000)) dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_sel_isr(mem_sel_isr), .mem_inst(mem_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .out_is_c(out_is_c), .out_isr(out_isr),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .int_req(int_req), .iret(iret), .in_isr(in_isr)
    );

    // Two ROMs of 2048 halfwords; a 32-bit read wraps from the last halfword to the first.
    logic [15:0] main_hw [2048];
    logic [15:0] isr_hw  [2048];
    logic [10:0] f_idx, f_nxt;

    always_comb begin
        f_idx = mem_addr[11:1];
        f_nxt = f_idx + 11'd1;
        if (mem_sel_isr) mem_inst = {isr_hw[f_nxt], isr_hw[f_idx]};
        else             mem_inst = {main_hw[f_nxt], main_hw[f_idx]};
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Architectural model state
    int          m_pc, m_epc, m_opc;
    bit          m_isr, m_pend, m_vld, m_c, m_oisr;
    logic [31:0] m_inst;

    function automatic logic [31:0] rom_word(input bit isr, input int pc);
        int lo, hi;
        lo = (pc / 2) % 2048;
        hi = (lo + 1) % 2048;
        return isr ? {isr_hw[hi], isr_hw[lo]} : {main_hw[hi], main_hw[lo]};
    endfunction

    task automatic model_step();
        bit          ld, took;
        logic [31:0] w;
        took = 0;
        if (rst) begin
            m_pc = 0; m_epc = 0; m_isr = 0; m_pend = 0; m_vld = 0;
            m_inst = 0; m_opc = 0; m_c = 0; m_oisr = 0;
        end else begin
            ld = !m_vld || out_ready;
            w  = rom_word(m_isr, m_pc);
            if (redirect_valid) begin
                m_pc  = int'(redirect_addr) & 'hFFE;
                m_vld = 0;
            end else if (iret && m_isr) begin
                m_pc  = m_epc;
                m_isr = 0;
                m_vld = 0;
            end else if (!m_isr && m_pend && ld) begin
                m_epc = m_pc;
                m_pc  = 0;
                m_isr = 1;
                m_vld = 0;
                took  = 1;
            end else if (ld) begin
                m_inst = w;
                m_opc  = m_pc;
                m_oisr = m_isr;
                m_c    = (w[1:0] != 2'b11);
                m_vld  = 1;
                m_pc   = (m_pc + (m_c ? 2 : 4)) % 4096;
            end
            m_pend = took ? 1'b0 : (m_pend | int_req);
        end
    endtask

    task automatic compare_all();
        logic [31:0] mask;
        mask = m_c ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        check_eq("out_valid",   out_valid,   m_vld);
        check_eq("in_isr",      in_isr,      m_isr);
        check_eq("mem_sel_isr", mem_sel_isr, m_isr);
        check_eq("mem_addr",    mem_addr,    m_pc);
        check_eq("out_pc",      out_pc,      m_opc);
        check_eq("out_is_c",    out_is_c,    m_c);
        check_eq("out_isr",     out_isr,     m_oisr);
        check_eq("out_inst",    out_inst & mask, m_inst & mask);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_inputs();
        rst = 0; out_ready = 1; redirect_valid = 0; redirect_addr = '0; int_req = 0; iret = 0;
    endtask

    initial begin
        logic [15:0] hw;
        for (int i = 0; i < 2048; i++) begin
            hw = 16'($urandom);
            if ($urandom_range(0, 1) == 1) hw[1:0] = 2'b11;
            else                           hw[1:0] = 2'($urandom_range(0, 2));
            main_hw[i] = hw;
            hw = 16'($urandom);
            if ($urandom_range(0, 1) == 1) hw[1:0] = 2'b11;
            else                           hw[1:0] = 2'($urandom_range(0, 2));
            isr_hw[i] = hw;
        end
        main_hw[0]    = 16'h1233;
        main_hw[1]    = 16'hABCD;
        main_hw[2]    = 16'h4561;
        main_hw[3]    = 16'h7777;
        main_hw[2047] = 16'h2223;

        m_pc = 0; m_epc = 0; m_opc = 0; m_isr = 0; m_pend = 0;
        m_vld = 0; m_c = 0; m_oisr = 0; m_inst = 0;

        idle_inputs();
        rst = 1;
        tick();
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_pc", mem_addr, 12'h000);
        check_eq("rst_inst", out_inst, 32'h0);

        // Sequential fetch: 32-bit, compressed, 32-bit
        rst = 0;
        tick();
        check_eq("seq0_pc", out_pc, 12'h000);
        check_eq("seq0_c", out_is_c, 1'b0);
        check_eq("seq0_inst", out_inst, 32'hABCD_1233);
        tick();
        check_eq("seq1_pc", out_pc, 12'h004);
        check_eq("seq1_c", out_is_c, 1'b1);
        tick();
        check_eq("seq2_pc", out_pc, 12'h006);
        check_eq("seq2_c", out_is_c, 1'b0);

        // Stall for three cycles, then release
        out_ready = 0;
        repeat (3) begin
            tick();
            check_eq("stall_pc", out_pc, 12'h006);
            check_eq("stall_addr", mem_addr, 12'h00A);
        end
        out_ready = 1;
        tick();
        check_eq("release_pc", out_pc, 12'h00A);

        // Interrupt round trip from pc=0x040
        redirect_valid = 1; redirect_addr = 12'h040; int_req = 1;
        tick();
        check_eq("irq_redir_bubble", out_valid, 1'b0);
        redirect_valid = 0; int_req = 0;
        tick();
        check_eq("irq_take_bubble", out_valid, 1'b0);
        check_eq("irq_sel", mem_sel_isr, 1'b1);
        tick();
        check_eq("isr_pc", out_pc, 12'h000);
        check_eq("isr_flag", out_isr, 1'b1);
        iret = 1;
        tick();
        check_eq("iret_bubble", out_valid, 1'b0);
        check_eq("iret_epc", mem_addr, 12'h040);
        iret = 0;
        tick();
        check_eq("ret_pc", out_pc, 12'h040);
        check_eq("ret_isr", out_isr, 1'b0);

        // Request during ISR is held and taken at the first load after iret
        int_req = 1; tick();
        int_req = 0; tick();
        check_eq("nest_in_isr", in_isr, 1'b1);
        tick();
        int_req = 1; tick();
        int_req = 0; tick();
        check_eq("nest_still_isr", in_isr, 1'b1);
        iret = 1; tick();
        check_eq("nest_iret_normal", in_isr, 1'b0);
        iret = 0; tick();
        check_eq("nest_retake", in_isr, 1'b1);
        check_eq("nest_retake_bubble", out_valid, 1'b0);
        tick();
        check_eq("nest_isr_pc", out_pc, 12'h000);

        // Redirect with simultaneous iret inside ISR
        redirect_valid = 1; redirect_addr = 12'h123; iret = 1;
        tick();
        check_eq("redir_bubble", out_valid, 1'b0);
        check_eq("redir_keep_isr", in_isr, 1'b1);
        redirect_valid = 0; iret = 0;
        tick();
        check_eq("redir_pc", out_pc, 12'h122);
        check_eq("redir_isr", out_isr, 1'b1);

        // 32-bit instruction at 0xFFE wraps to halfword 0
        iret = 1; tick();
        iret = 0; redirect_valid = 1; redirect_addr = 12'hFFE; tick();
        redirect_valid = 0; tick();
        check_eq("wrap_pc", out_pc, 12'hFFE);
        check_eq("wrap_inst", out_inst, 32'h1233_2223);
        check_eq("wrap_next", mem_addr, 12'h002);

        // Reset while in ISR with a pending request
        int_req = 1; tick();
        int_req = 0; tick();
        int_req = 1; tick();
        int_req = 0; rst = 1; tick();
        check_eq("rst_isr_state", in_isr, 1'b0);
        check_eq("rst_isr_valid", out_valid, 1'b0);
        check_eq("rst_isr_pc", mem_addr, 12'h000);
        rst = 0;
        repeat (5) tick();
        check_eq("rst_no_irq", in_isr, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst            = ($urandom_range(0, 199) == 0);
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_addr  = AW'($urandom_range(0, 4095));
            int_req        = ($urandom_range(0, 19) == 0);
            iret           = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
